pe_mean_acc: RTL and testbench

PE_MEAN_ACC -- requirements
Module: pe_mean_acc

---
 rtl/pe_mean_pkg.sv | 20 ++
 rtl/pe_sat_shift.sv | 47 ++++
 rtl/pe_mean_acc.sv | 157 +++++++++++++++
 tb/tb_pe_mean_acc.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pe_mean_pkg.sv
// Shared types and constants for the pe_mean_acc group-mean engine.
// Holds the FSM state encoding, the sample-count width and the default datapath widths.
package pe_mean_pkg;

  localparam int CNT_W          = 8;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ACC_W      = 24;
  localparam int DEF_FRAC_SHIFT = 14;

  // A group is forced closed when its count reaches this value.
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    ACC    = 2'd0,
    LOOKUP = 2'd1,
    MUL    = 2'd2,
    OUT    = 2'd3
  } state_e;

endpackage

// File: rtl/pe_sat_shift.sv
// Combinational arithmetic right shift with saturation to a narrower signed width.
// Optional round-half-up before the shift when PE_MEAN_ROUND_EN is defined.
module pe_sat_shift #(
  parameter int IN_W  = 41,
  parameter int OUT_W = 16,
  parameter int SHIFT = 14
) (
  input  logic signed [IN_W-1:0]  i_data,
  output logic signed [OUT_W-1:0] o_data
);

  localparam int EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_rnd;
  logic signed [EXT_W-1:0] w_shr;

  // One guard bit keeps the rounding add from wrapping near full scale.
  assign w_ext = {i_data[IN_W-1], i_data};

`ifdef PE_MEAN_ROUND_EN
  localparam logic signed [EXT_W-1:0] RND_ADD =
    {{(EXT_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  assign w_rnd = w_ext + RND_ADD;
`else
  assign w_rnd = w_ext;
`endif

  assign w_shr = w_rnd >>> SHIFT;

  // Clamp the shifted value into the output range.
  always_comb begin
    o_data = w_shr[OUT_W-1:0];
    if (w_shr > SAT_MAX) begin
      o_data = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_shr < SAT_MIN) begin
      o_data = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      o_data = w_shr[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/pe_mean_acc.sv
// Streaming group mean: accumulates signed samples, multiplies by an external reciprocal,
// then shifts and saturates. Define PE_MEAN_ROUND_EN for round-half-up before the shift.
module pe_mean_acc
  import pe_mean_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         out_count,
  output logic [CNT_W-1:0]         lut_index,
  output logic                     lut_enable,
  input  logic [15:0]              lut_value
);

  localparam int PROD_W = ACC_W + 17;

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic signed [ACC_W-1:0]   r_sum;
  logic [CNT_W-1:0]          r_count;
  logic [15:0]               r_lut;
  logic                      r_out_valid;
  logic signed [DATA_W-1:0]  r_out_data;
  logic [CNT_W-1:0]          r_out_count;
  logic                      r_lut_enable;
  logic [CNT_W-1:0]          r_lut_index;

  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_group_end;
  logic [CNT_W-1:0]          w_count_inc;
  logic signed [ACC_W-1:0]   w_sample_ext;
  logic signed [PROD_W-1:0]  w_sum_ext;
  logic signed [PROD_W-1:0]  w_lut_ext;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [DATA_W-1:0]  w_mean;

  // Ready is gated by rst so it is low throughout reset and high the first cycle after.
  assign w_in_ready   = (r_state == ACC) && !rst;
  assign w_accept     = in_valid && w_in_ready;
  assign w_count_inc  = r_count + CNT_W'(1);
  assign w_group_end  = in_last || (w_count_inc == CNT_MAX);
  assign w_sample_ext = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

  // Reciprocal is unsigned, so it enters the signed product zero-extended.
  assign w_sum_ext = {{(PROD_W-ACC_W){r_sum[ACC_W-1]}}, r_sum};
  assign w_lut_ext = {{(PROD_W-16){1'b0}}, r_lut};
  assign w_prod    = w_sum_ext * w_lut_ext;

  pe_sat_shift #(
    .IN_W  (PROD_W),
    .OUT_W (DATA_W),
    .SHIFT (FRAC_SHIFT)
  ) u_sat_shift (
    .i_data (w_prod),
    .o_data (w_mean)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC: begin
        if (w_accept && w_group_end) begin
          w_state_nxt = LOOKUP;
        end else begin
          w_state_nxt = ACC;
        end
      end
      LOOKUP: w_state_nxt = MUL;
      MUL:    w_state_nxt = OUT;
      OUT: begin
        if (r_out_valid && out_ready) begin
          w_state_nxt = ACC;
        end else begin
          w_state_nxt = OUT;
        end
      end
      default: w_state_nxt = ACC;
    endcase
  end

  // Accumulator, reciprocal capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum        <= '0;
      r_count      <= '0;
      r_lut        <= 16'h0000;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_count  <= '0;
      r_lut_enable <= 1'b0;
      r_lut_index  <= '0;
    end else begin
      case (r_state)
        ACC: begin
          if (w_accept) begin
            r_sum   <= r_sum + w_sample_ext;
            r_count <= w_count_inc;
            if (w_group_end) begin
              r_lut_enable <= 1'b1;
              r_lut_index  <= w_count_inc;
            end
          end
        end
        LOOKUP: begin
          r_lut        <= lut_value;
          r_lut_enable <= 1'b0;
          r_lut_index  <= '0;
        end
        MUL: begin
          r_out_data  <= w_mean;
          r_out_count <= r_count;
          r_out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_count     <= '0;
          end
        end
        default: begin
          r_lut_enable <= 1'b0;
          r_lut_index  <= '0;
        end
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_count  = r_out_count;
  assign lut_enable = r_lut_enable;
  assign lut_index  = r_lut_index;

endmodule

// File: tb/tb_pe_mean_acc.sv
// Directed bench for pe_mean_acc: reciprocal table model, latency, saturation,
// back-pressure and mid-group reset scenarios with hand-computed results.
module tb_pe_mean_acc;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic [7:0]         out_count;
  logic [7:0]         lut_index;
  logic               lut_enable;
  logic [15:0]        lut_value;

  int errors = 0;
  int checks = 0;

  pe_mean_acc dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .lut_index  (lut_index),
    .lut_enable (lut_enable),
    .lut_value  (lut_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] recip(input logic [7:0] idx);
    case (idx)
      8'd1:    recip = 16'h4dbc;
      8'd2:    recip = 16'h2000;
      8'd3:    recip = 16'h679f;
      8'd4:    recip = 16'h4db7;
      8'd255:  recip = 16'h0138;
      default: recip = 16'h0000;
    endcase
  endfunction

  always_comb lut_value = recip(lut_index);

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [15:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called just after the edge that accepted the closing sample (end of cycle t).
  task automatic finish_group(input int n, input int exp_data, input int hold);
    @(negedge clk);
    chk("lookup_en", lut_enable, 1);
    chk("lookup_idx", lut_index, n);
    chk("lookup_rdy", in_ready, 0);
    chk("lookup_valid", out_valid, 0);
    @(negedge clk);
    chk("mul_valid", out_valid, 0);
    chk("mul_lut_en", lut_enable, 0);
    chk("mul_lut_idx", lut_index, 0);
    chk("mul_rdy", in_ready, 0);
    @(negedge clk);
    chk("out_valid_t3", out_valid, 1);
    chk("out_data", $signed(out_data), exp_data);
    chk("out_count", out_count, n);
    chk("out_rdy", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", $signed(out_data), exp_data);
      chk("hold_count", out_count, n);
      chk("hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("acc_valid", out_valid, 0);
    chk("acc_rdy", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'sd0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_lut_en", lut_enable, 0);
    chk("rst_lut_idx", lut_index, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", in_ready, 1);
    @(posedge clk);
    #1;

    // 600 * 0x679f >> 14 = 971, then back-pressure for 5 cycles.
    send(16'sd100, 1'b0);
    send(16'sd200, 1'b0);
    send(16'sd300, 1'b1);
    finish_group(3, 971, 5);

    // 1000 * 0x4dbc >> 14 = 1214.6
`ifdef PE_MEAN_ROUND_EN
    send(16'sd1000, 1'b1);
    finish_group(1, 1215, 0);
`else
    send(16'sd1000, 1'b1);
    finish_group(1, 1214, 0);
`endif

    // Forced group end at 255 samples; positive saturation.
    for (int i = 0; i < 255; i++) begin
      send(16'sd32767, 1'b0);
    end
    finish_group(255, 32767, 0);

    // -65536 * 0x4db7 >> 14 = -79580 -> negative saturation.
    send(-16'sd16384, 1'b0);
    send(-16'sd16384, 1'b0);
    send(-16'sd16384, 1'b0);
    send(-16'sd16384, 1'b1);
    finish_group(4, -32768, 0);

    // Partial group discarded by reset; only 10+20 contribute: 30*0x2000>>14 = 15.
    send(16'sd500, 1'b0);
    send(16'sd700, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_rdy", in_ready, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_lut_en", lut_enable, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_post_rdy", in_ready, 1);
    @(posedge clk);
    #1;
    send(16'sd10, 1'b0);
    send(16'sd20, 1'b1);
    finish_group(2, 15, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
